// File: rtl/dmem_sized.sv
// Byte/half/word data memory with sign/zero-extended loads, error reporting and a post-reset clear engine.
// Registered response one cycle after acceptance; req_ready low only while clearing, response channel never stalls.
module dmem_sized #(
  parameter int DATA_LEN       = 32,
  parameter int ADDR_LEN       = 32,
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [DATA_LEN-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                init_busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic [3:0][7:0] r_mem [DEPTH];

  logic            w_accept;
  logic            w_oor;
  logic            w_err;
  logic            w_we;
  logic            w_clr;
  logic [AW-1:0]   w_idx;
  logic [1:0]      w_lane;
  logic [3:0][7:0] w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load;
  logic [3:0]      w_be;
  logic [3:0][7:0] w_wlanes;

  // Gating with rst keeps a store presented at the reset edge from landing.
  assign w_accept = rst && req_valid && req_ready;
  assign w_idx    = req_addr[AW+1:2];
  assign w_lane   = req_addr[1:0];
  assign w_oor    = (req_addr >> (AW + 2)) != '0;
  assign w_err    = (req_size == 2'b11)
                 || (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                 || w_oor;
  assign w_we     = w_accept && req_write && !w_err;
  assign w_clr    = rst && (r_state == S_INIT);

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[w_lane];
  assign w_half = w_lane[1] ? w_word[3:2] : w_word[1:0];

  always_comb begin
    w_load = w_word;
    case (req_size)
      2'b00:   w_load = {{24{~req_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~req_unsigned & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = req_wdata;
    case (req_size)
      2'b00: begin
        w_be     = 4'b0001 << w_lane;
        w_wlanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{req_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= CLEAR_ON_RESET ? S_INIT : S_RUN;
      r_cnt     <= '0;
      req_ready <= !CLEAR_ON_RESET;
      init_busy <= CLEAR_ON_RESET;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= w_accept;
      rsp_err   <= w_accept && w_err;
      rsp_rdata <= (w_accept && !req_write && !w_err) ? w_load : '0;
      case (r_state)
        S_INIT: begin
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            req_ready <= 1'b1;
            init_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Storage carries no reset; the clear engine owns it during INIT.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_mem[r_cnt] <= '0;
    end else if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b] <= w_wlanes[b];
      end
    end
  end

endmodule
